// File: rtl/hid_evq.sv
// hid_evq: MCU byte-stream HID command parser with a rate-limited keyboard/mouse event queue,
// joystick registers, DB9 change interrupt and LCTRL+LAMIGA+RAMIGA reset-combo detection.
module hid_evq #(
    parameter int unsigned NUM_JOY    = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned EVT_GAP    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 data_in_strobe,
    input  logic                 data_in_start,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic [5:0]           db9_port,
    output logic                 irq,
    input  logic                 iack,
    output logic [2:0]           mouse_buttons,
    output logic                 kbd_mouse_level,
    output logic [1:0]           kbd_mouse_type,
    output logic [7:0]           kbd_mouse_data,
    output logic                 kbd_reset,
    output logic [8*NUM_JOY-1:0] joystick
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GapW = (EVT_GAP > 1) ? $clog2(EVT_GAP) : 1;

    logic [7:0]           cmd_q, cmd_d, data_out_q, data_out_d, device_q, device_d;
    logic [3:0]           state_q, state_d;
    logic [8*NUM_JOY-1:0] joy_q, joy_d;
    logic [2:0]           buttons_q, buttons_d;
    logic                 lctrl_q, lctrl_d, lamiga_q, lamiga_d, ramiga_q, ramiga_d;
    logic                 combo_prev_q, combo_prev_d, kbd_reset_q, kbd_reset_d;
    logic                 overflow_q, overflow_d, irq_q, irq_d, irq_en_q, irq_en_d;
    logic [5:0]           db9_s1_q, db9_s2_q;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic                 level_q, level_d;
    logic [1:0]           type_q, type_d;
    logic [7:0]           evdata_q, evdata_d;

    logic [9:0]           mem [FIFO_DEPTH];
    logic [9:0]           push_entry, rd_entry;
    logic                 push, push_ok, pop, full, combo;
    logic [6:0]           key;
    logic [7:0]           cnt_ext;
    logic [3:0]           cnt_sat;

    // Raw codes 0x68..0x7f have no Amiga key and map to the "no key" code 0x7f.
    assign key      = (data_in[6:0] >= 7'h68) ? 7'h7f : data_in[6:0];
    assign full     = (count_q == CntW'(FIFO_DEPTH));
    assign pop      = (gap_q == '0) && (count_q != '0);
    assign combo    = lctrl_q & lamiga_q & ramiga_q;
    assign cnt_ext  = 8'(count_q);
    assign cnt_sat  = (cnt_ext > 8'd15) ? 4'hf : cnt_ext[3:0];
    assign rd_entry = mem[rd_ptr_q];

    always_comb begin
        cmd_d        = cmd_q;
        state_d      = state_q;
        data_out_d   = data_out_q;
        device_d     = device_q;
        joy_d        = joy_q;
        buttons_d    = buttons_q;
        lctrl_d      = lctrl_q;
        lamiga_d     = lamiga_q;
        ramiga_d     = ramiga_q;
        overflow_d   = overflow_q;
        irq_d        = irq_q;
        irq_en_d     = irq_en_q;
        push         = 1'b0;
        push_entry   = '0;
        combo_prev_d = combo;
        kbd_reset_d  = combo & ~combo_prev_q;

        if (irq_en_q && (db9_s1_q != db9_s2_q)) begin
            irq_d    = 1'b1;
            irq_en_d = 1'b0;
        end

        if (data_in_strobe && data_in_start) begin
            cmd_d   = data_in;
            state_d = '0;
        end else if (data_in_strobe) begin
            if (state_q != 4'hf) state_d = state_q + 4'd1;
            case (cmd_q)
                8'd0: begin
                    case (state_q)
                        4'd0: data_out_d = 8'h02;
                        4'd1: data_out_d = 8'h00;
                        4'd2: begin
                            data_out_d = {overflow_q, 3'b000, cnt_sat};
                            overflow_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
                8'd1: begin
                    if (state_q == 4'd0) begin
                        if (key != 7'h7f) begin
                            push       = 1'b1;
                            push_entry = {2'd2, data_in[7], key};
                        end
                        if (key == 7'h63) lctrl_d  = ~data_in[7];
                        if (key == 7'h66) lamiga_d = ~data_in[7];
                        if (key == 7'h67) ramiga_d = ~data_in[7];
                    end
                end
                8'd2: begin
                    case (state_q)
                        4'd0: buttons_d = data_in[2:0];
                        4'd1: begin
                            push       = 1'b1;
                            push_entry = {2'd0, data_in};
                        end
                        4'd2: begin
                            push       = 1'b1;
                            push_entry = {2'd1, data_in};
                        end
                        default: ;
                    endcase
                end
                8'd3: begin
                    if (state_q == 4'd0) begin
                        device_d = data_in;
                    end else if (state_q == 4'd1) begin
                        for (int unsigned i = 0; i < NUM_JOY; i++) begin
                            if (device_q == 8'(i)) joy_d[8*i +: 8] = data_in;
                        end
                    end
                end
                8'd4: begin
                    data_out_d = {2'b00, db9_s2_q};
                    if (state_q == 4'd0) irq_en_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (iack) irq_d = 1'b0;

        // A push into a full queue is dropped even when a pop frees a slot this cycle.
        push_ok = push && !full;
        if (push && full) overflow_d = 1'b1;

        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: ;
        endcase

        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        type_d   = type_q;
        evdata_d = evdata_q;
        gap_d    = (gap_q != '0) ? gap_q - GapW'(1) : gap_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            level_d  = ~level_q;
            type_d   = rd_entry[9:8];
            evdata_d = rd_entry[7:0];
            gap_d    = GapW'(EVT_GAP - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q        <= '0;
            state_q      <= '0;
            data_out_q   <= '0;
            device_q     <= '0;
            joy_q        <= '0;
            buttons_q    <= '0;
            lctrl_q      <= 1'b0;
            lamiga_q     <= 1'b0;
            ramiga_q     <= 1'b0;
            combo_prev_q <= 1'b0;
            kbd_reset_q  <= 1'b0;
            overflow_q   <= 1'b0;
            irq_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            db9_s1_q     <= '0;
            db9_s2_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            gap_q        <= '0;
            level_q      <= 1'b0;
            type_q       <= '0;
            evdata_q     <= '0;
        end else begin
            cmd_q        <= cmd_d;
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            device_q     <= device_d;
            joy_q        <= joy_d;
            buttons_q    <= buttons_d;
            lctrl_q      <= lctrl_d;
            lamiga_q     <= lamiga_d;
            ramiga_q     <= ramiga_d;
            combo_prev_q <= combo_prev_d;
            kbd_reset_q  <= kbd_reset_d;
            overflow_q   <= overflow_d;
            irq_q        <= irq_d;
            irq_en_q     <= irq_en_d;
            db9_s1_q     <= db9_port;
            db9_s2_q     <= db9_s1_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            gap_q        <= gap_d;
            level_q      <= level_d;
            type_q       <= type_d;
            evdata_q     <= evdata_d;
        end
    end

    assign data_out        = data_out_q;
    assign irq             = irq_q;
    assign mouse_buttons   = buttons_q;
    assign kbd_mouse_level = level_q;
    assign kbd_mouse_type  = type_q;
    assign kbd_mouse_data  = evdata_q;
    assign kbd_reset       = kbd_reset_q;
    assign joystick        = joy_q;

endmodule

// File: tb/tb_hid_evq.sv
// Self-checking bench for hid_evq: directed scenarios plus a random byte stream, compared every
// cycle against a queue-based behavioural model of the command protocol and event timing.
module tb_hid_evq;
    localparam int unsigned NUM_JOY    = 2;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned EVT_GAP    = 32;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 strobe = 1'b0, start = 1'b0, iack = 1'b0;
    logic [7:0]           din = '0;
    logic [5:0]           db9 = '0;
    logic [7:0]           data_out;
    logic                 irq, kbd_mouse_level, kbd_reset;
    logic [2:0]           mouse_buttons;
    logic [1:0]           kbd_mouse_type;
    logic [7:0]           kbd_mouse_data;
    logic [8*NUM_JOY-1:0] joystick;

    hid_evq #(.NUM_JOY(NUM_JOY), .FIFO_DEPTH(FIFO_DEPTH), .EVT_GAP(EVT_GAP)) dut (
        .clk(clk), .reset_n(reset_n), .data_in_strobe(strobe), .data_in_start(start),
        .data_in(din), .data_out(data_out), .db9_port(db9), .irq(irq), .iack(iack),
        .mouse_buttons(mouse_buttons), .kbd_mouse_level(kbd_mouse_level),
        .kbd_mouse_type(kbd_mouse_type), .kbd_mouse_data(kbd_mouse_data),
        .kbd_reset(kbd_reset), .joystick(joystick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Behavioural model state
    bit [7:0]           m_cmd, m_dout, m_dev, m_data;
    int                 m_state, m_cyc, m_next_ok;
    bit [8*NUM_JOY-1:0] m_joy;
    bit [2:0]           m_btn;
    bit [1:0]           m_type;
    bit                 m_lctrl, m_lamiga, m_ramiga, m_combo_prev, m_kreset;
    bit                 m_ovf, m_irq, m_irq_en, m_level;
    bit [5:0]           m_s1, m_s2;
    bit [9:0]           mq[$];

    // Observation counters
    int  toggles, kres_cnt;
    int  toggle_cyc[$];
    bit  prev_level;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd = 0; m_dout = 0; m_dev = 0; m_data = 0; m_state = 0; m_cyc = 0; m_next_ok = 0;
        m_joy = 0; m_btn = 0; m_type = 0; m_lctrl = 0; m_lamiga = 0; m_ramiga = 0;
        m_combo_prev = 0; m_kreset = 0; m_ovf = 0; m_irq = 0; m_irq_en = 0; m_level = 0;
        m_s1 = 0; m_s2 = 0;
        mq.delete();
    endtask

    task automatic model_step();
        bit [9:0] pe, e;
        bit       push, combo;
        bit [6:0] key;
        bit [7:0] cnt;
        int       occ;
        m_cyc++;
        occ  = mq.size();
        push = 0;
        pe   = '0;
        combo        = m_lctrl & m_lamiga & m_ramiga;
        m_kreset     = combo & ~m_combo_prev;
        m_combo_prev = combo;
        if (m_irq_en && (m_s1 != m_s2)) begin
            m_irq    = 1;
            m_irq_en = 0;
        end
        if (strobe && start) begin
            m_cmd   = din;
            m_state = 0;
        end else if (strobe) begin
            case (m_cmd)
                8'd0: begin
                    if (m_state == 0) m_dout = 8'h02;
                    else if (m_state == 1) m_dout = 8'h00;
                    else if (m_state == 2) begin
                        cnt    = (occ > 15) ? 8'd15 : 8'(occ);
                        m_dout = {m_ovf, 3'b000, cnt[3:0]};
                        m_ovf  = 0;
                    end
                end
                8'd1: if (m_state == 0) begin
                    key = (din[6:0] >= 7'h68) ? 7'h7f : din[6:0];
                    if (key != 7'h7f) begin
                        push = 1;
                        pe   = {2'd2, din[7], key};
                    end
                    if (key == 7'h63) m_lctrl  = ~din[7];
                    if (key == 7'h66) m_lamiga = ~din[7];
                    if (key == 7'h67) m_ramiga = ~din[7];
                end
                8'd2: begin
                    if (m_state == 0) m_btn = din[2:0];
                    else if (m_state == 1) begin push = 1; pe = {2'd0, din}; end
                    else if (m_state == 2) begin push = 1; pe = {2'd1, din}; end
                end
                8'd3: begin
                    if (m_state == 0) m_dev = din;
                    else if (m_state == 1 && m_dev < NUM_JOY) m_joy[m_dev*8 +: 8] = din;
                end
                8'd4: begin
                    m_dout = {2'b00, m_s2};
                    if (m_state == 0) m_irq_en = 1;
                end
                default: ;
            endcase
            if (m_state < 15) m_state++;
        end
        if (occ > 0 && m_cyc >= m_next_ok) begin
            e         = mq.pop_front();
            m_level   = ~m_level;
            m_type    = e[9:8];
            m_data    = e[7:0];
            m_next_ok = m_cyc + EVT_GAP;
        end
        if (push) begin
            if (occ == FIFO_DEPTH) m_ovf = 1;
            else mq.push_back(pe);
        end
        if (iack) m_irq = 0;
        m_s2 = m_s1;
        m_s1 = db9;
    endtask

    task automatic compare_all();
        chk("level", kbd_mouse_level, m_level);
        chk("type", kbd_mouse_type, m_type);
        chk("evdata", kbd_mouse_data, m_data);
        chk("data_out", data_out, m_dout);
        chk("buttons", mouse_buttons, m_btn);
        chk("kbd_reset", kbd_reset, m_kreset);
        chk("irq", irq, m_irq);
        chk("joystick", joystick, m_joy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        compare_all();
        if (kbd_mouse_level !== prev_level) begin
            toggles++;
            toggle_cyc.push_back(m_cyc);
        end
        prev_level = kbd_mouse_level;
        if (kbd_reset === 1'b1) kres_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input bit st, input bit [7:0] d);
        strobe = 1'b1;
        start  = st;
        din    = d;
        tick();
        strobe = 1'b0;
        start  = 1'b0;
    endtask

    task automatic clear_obs();
        toggles  = 0;
        kres_cnt = 0;
        toggle_cyc.delete();
    endtask

    initial begin
        bit [7:0] ck[3];
        int       j, t;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        prev_level = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Mouse packet: buttons immediate, two events EVT_GAP apart
        clear_obs();
        send_byte(1, 8'd2);
        send_byte(0, 8'h05);
        send_byte(0, 8'h03);
        send_byte(0, 8'hFD);
        chk("mouse_buttons5", mouse_buttons, 3'd5);
        idle(2 * EVT_GAP + 4);
        chk("mouse_toggles", toggles, 2);
        if (toggle_cyc.size() >= 2) chk("mouse_gap", toggle_cyc[1] - toggle_cyc[0], EVT_GAP);

        // Keyboard burst overflows the queue
        for (int i = 0; i < 10; i++) begin
            send_byte(1, 8'd1);
            send_byte(0, {1'($urandom_range(0, 1)), 7'($urandom_range(0, 'h5f))});
        end
        send_byte(1, 8'd0);
        send_byte(0, 8'h00);
        chk("status_version", data_out, 8'h02);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        chk("status_ovf_set", data_out[7], 1'b1);
        idle(12 * EVT_GAP);
        send_byte(1, 8'd0);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        chk("status_ovf_clr", data_out, 8'h00);

        // Reset combo in random order, then release/re-press one key
        ck[0] = 8'h63; ck[1] = 8'h66; ck[2] = 8'h67;
        for (int i = 2; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ck[i]; ck[i] = ck[j]; ck[j] = 8'(t);
        end
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            send_byte(1, 8'd1);
            send_byte(0, ck[i]);
        end
        idle(4);
        chk("combo_one_pulse", kres_cnt, 1);
        send_byte(1, 8'd1);
        send_byte(0, ck[1] | 8'h80);
        send_byte(1, 8'd1);
        send_byte(0, ck[1]);
        idle(4);
        chk("combo_second_pulse", kres_cnt, 2);
        idle(6 * EVT_GAP);
        clear_obs();
        send_byte(1, 8'd1);
        send_byte(0, 8'h7f);
        idle(EVT_GAP + 4);
        chk("unmapped_no_event", toggles, 0);

        // Joystick writes
        send_byte(1, 8'd3);
        send_byte(0, 8'd1);
        send_byte(0, 8'hA5);
        chk("joy1_a5", joystick[15:8], 8'hA5);
        send_byte(1, 8'd3);
        send_byte(0, 8'd2);
        send_byte(0, 8'h3C);
        chk("joy_dev2_ignored", joystick[15:8], 8'hA5);

        // DB9 change interrupt
        send_byte(1, 8'd4);
        send_byte(0, 8'h00);
        db9[0] = ~db9[0];
        tick();
        chk("irq_not_yet", irq, 1'b0);
        idle(2);
        chk("irq_set", irq, 1'b1);
        db9[1] = ~db9[1];
        idle(4);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        chk("irq_acked", irq, 1'b0);
        db9[2] = ~db9[2];
        idle(4);
        chk("irq_disarmed", irq, 1'b0);
        send_byte(1, 8'd4);
        send_byte(0, 8'h00);
        chk("db9_readback", data_out, {2'b00, db9});
        db9[0] = ~db9[0];
        idle(4);
        chk("irq_rearmed", irq, 1'b1);
        iack = 1'b1;
        tick();
        iack = 1'b0;

        // Random byte stream
        for (int i = 0; i < 600; i++) begin
            strobe = 1'($urandom_range(0, 1));
            start  = ($urandom_range(0, 3) == 0);
            din    = start ? 8'($urandom_range(0, 5)) : 8'($urandom);
            if ($urandom_range(0, 15) == 0) db9 = 6'($urandom);
            iack = ($urandom_range(0, 7) == 0);
            tick();
        end
        strobe = 1'b0;
        start  = 1'b0;
        iack   = 1'b0;
        idle(3);

        // Asynchronous reset with events queued
        send_byte(1, 8'd2);
        send_byte(0, 8'h07);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(1, 8'd1);
        send_byte(0, 8'h20);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("reset_level_zero", kbd_mouse_level, 1'b0);
        prev_level = 1'b0;
        idle(3);
        reset_n = 1'b1;
        clear_obs();
        idle(3 * EVT_GAP);
        chk("no_toggle_after_reset", toggles, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
